// File: rtl/full_adder_if.sv
// full_adder_if -- operand/result bundle for the registered full adder.
//
// Signals:
//   in_valid  : operands a/b/cin are valid this cycle (master -> slave)
//   a, b      : unsigned operands, WIDTH bits           (master -> slave)
//   cin       : carry-in                                (master -> slave)
//   sum       : registered sum bits [WIDTH-1:0]         (slave -> master)
//   cout      : registered carry-out                    (slave -> master)
//   out_valid : sum/cout hold a new result this cycle   (slave -> master)
//   ovf       : registered signed overflow, only when FULL_ADDER_OVF_EN
//               is defined                              (slave -> master)
//
// Handshake: valid-only, no back-pressure. A transfer happens on every
// rising edge where in_valid=1 (and reset is not asserted); the matching
// result appears one cycle later with out_valid=1 for exactly that cycle.
// The consumer must take the result when out_valid is high.
//
// Optional feature macro: FULL_ADDER_OVF_EN (adds ovf).
interface full_adder_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
`ifdef FULL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
`ifdef FULL_ADDER_OVF_EN
    input  ovf,
`endif
    output in_valid, a, b, cin,
    input  sum, cout, out_valid
  );

  modport slave (
`ifdef FULL_ADDER_OVF_EN
    output ovf,
`endif
    input  in_valid, a, b, cin,
    output sum, cout, out_valid
  );
endinterface

// File: rtl/full_adder.sv
// full_adder -- registered, width-parameterised ripple-carry full adder.
//
// {cout, sum} = a + b + cin, computed at WIDTH+1 bits by a chain of WIDTH
// identical 1-bit full-adder cells, then captured in one output register
// stage. Latency is exactly one cycle; there is no combinational path from
// any input to any output.
//
// Parameters:
//   WIDTH : operand and sum width, 1..64 (WIDTH=1 is the classic FA cell)
//
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset; clears sum/cout/out_valid(/ovf)
//           and has priority over in_valid
//   bus   : full_adder_if.slave (in_valid, a, b, cin -> sum, cout,
//           out_valid, and ovf when enabled)
//
// Optional feature macro: FULL_ADDER_OVF_EN -- adds the registered signed
// two's-complement overflow flag ovf = c[WIDTH] ^ c[WIDTH-1].

// One bit of the ripple chain.
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  full_adder_if.slave  bus
);

  // carry[0] is cin, carry[i+1] is the carry out of bit i, carry[WIDTH] is cout.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_core;

  assign carry[0] = bus.cin;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_cell u_cell (
        .a_i (bus.a[i]),
        .b_i (bus.b[i]),
        .c_i (carry[i]),
        .s_o (sum_core[i]),
        .c_o (carry[i+1])
      );
    end
  endgenerate

  logic [WIDTH-1:0] sum_d,  sum_q;
  logic             cout_d, cout_q;
  logic             out_valid_d, out_valid_q;

  // Result registers hold when no new operands arrive; out_valid is a
  // one-cycle pulse per accepted operand set.
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      sum_d       = sum_core;
      cout_d      = carry[WIDTH];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = out_valid_q;

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  // For WIDTH=1 the carry into the sign bit is cin itself (carry[0]).
  logic ovf_d, ovf_q;

  always_comb begin
    ovf_d = ovf_q;
    if (bus.in_valid) begin
      ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder -- directed, table-driven bench for full_adder.
// Three instances: WIDTH=1 (truth table, reset), WIDTH=8 (hold, carry
// ripple), WIDTH=4 (streaming, overflow when FULL_ADDER_OVF_EN is defined).
// Inputs are driven on the falling edge; outputs are sampled #1 after the
// rising edge.
module tb_full_adder;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  full_adder_if #(.WIDTH(1)) if1 ();
  full_adder_if #(.WIDTH(8)) if8 ();
  full_adder_if #(.WIDTH(4)) if4 ();

  full_adder #(.WIDTH(1)) u_fa1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  full_adder #(.WIDTH(8)) u_fa8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  full_adder #(.WIDTH(4)) u_fa4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  // ---------------- scoreboard / counters ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;   // {cout, sum}
  } vec_t;

  vec_t tt1 [8];
  vec_t tt8 [6];

  // ---------------- driver tasks ----------------
  task automatic drive1(input logic v, input logic a, input logic b, input logic c);
    @(negedge clk);
    if1.in_valid = v; if1.a = a; if1.b = b; if1.cin = c;
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    if8.in_valid = v; if8.a = a; if8.b = b; if8.cin = c;
  endtask

  task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
    @(negedge clk);
    if4.in_valid = v; if4.a = a; if4.b = b; if4.cin = c;
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [3:0] ra, rb;
    logic       rc;
    logic [4:0] e;

    // WIDTH=1 truth table in order abc = 000..111; (sum,cout) =
    // 00,10,10,01,10,01,01,11 -> {cout,sum} = 0,1,1,2,1,2,2,3.
    tt1[0] = '{8'd0, 8'd0, 1'b0, 9'd0};
    tt1[1] = '{8'd0, 8'd0, 1'b1, 9'd1};
    tt1[2] = '{8'd0, 8'd1, 1'b0, 9'd1};
    tt1[3] = '{8'd0, 8'd1, 1'b1, 9'd2};
    tt1[4] = '{8'd1, 8'd0, 1'b0, 9'd1};
    tt1[5] = '{8'd1, 8'd0, 1'b1, 9'd2};
    tt1[6] = '{8'd1, 8'd1, 1'b0, 9'd2};
    tt1[7] = '{8'd1, 8'd1, 1'b1, 9'd3};

    // WIDTH=8 directed vectors, hand-computed.
    tt8[0] = '{8'h3C, 8'h0F, 1'b0, 9'h04B};
    tt8[1] = '{8'hFF, 8'h00, 1'b1, 9'h100};
    tt8[2] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    tt8[3] = '{8'h00, 8'h00, 1'b0, 9'h000};
    tt8[4] = '{8'h80, 8'h80, 1'b0, 9'h100};
    tt8[5] = '{8'h12, 8'h34, 1'b1, 9'h047};

    rst_n = 1'b0;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;

    // Reset state of all instances.
    repeat (2) sample();
    check("rst_w1_out", {if1.out_valid, if1.cout, if1.sum}, 64'h0);
    check("rst_w8_out", {if8.out_valid, if8.cout, if8.sum}, 64'h0);
    check("rst_w4_out", {if4.out_valid, if4.cout, if4.sum}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- WIDTH=1 exhaustive truth table ----
    for (int i = 0; i < 8; i++) begin
      drive1(1'b1, tt1[i].a[0], tt1[i].b[0], tt1[i].cin);
      sample();
      check($sformatf("w1_tt%0d", i), {if1.cout, if1.sum}, 64'(tt1[i].exp[1:0]));
      check($sformatf("w1_tt%0d_valid", i), 64'(if1.out_valid), 64'h1);
    end

    // ---- reset with in_valid high: reset wins, then first result ----
    @(negedge clk);
    rst_n = 1'b0;
    if1.in_valid = 1'b1; if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      check($sformatf("w1_rst_hold%0d", i), {if1.out_valid, if1.cout, if1.sum}, 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sample();
    check("w1_after_rst", {if1.out_valid, if1.cout, if1.sum}, 64'h7);
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    check("w1_idle_hold", {if1.out_valid, if1.cout, if1.sum}, 64'h3);

    // ---- WIDTH=8 directed table ----
    for (int i = 0; i < 6; i++) begin
      drive8(1'b1, tt8[i].a, tt8[i].b, tt8[i].cin);
      sample();
      check($sformatf("w8_vec%0d", i), {if8.cout, if8.sum}, 64'(tt8[i].exp));
      check($sformatf("w8_vec%0d_valid", i), 64'(if8.out_valid), 64'h1);
    end

    // ---- WIDTH=8 hold: result stays while in_valid=0 ----
    drive8(1'b1, 8'h3C, 8'h0F, 1'b0);
    sample();
    check("w8_hold_load", {if8.cout, if8.sum}, 64'h04B);
    drive8(1'b0, 8'hFF, 8'h00, 1'b1);
    for (int i = 0; i < 2; i++) begin
      sample();
      check($sformatf("w8_hold%0d", i), {if8.out_valid, if8.cout, if8.sum}, 64'h04B);
    end

    // ---- WIDTH=4 back-to-back streaming, 16 random sets ----
    for (int i = 0; i < 16; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      exp_q.push_back(5'(ra) + 5'(rb) + 5'(rc));
      drive4(1'b1, ra, rb, rc);
      sample();
      e = exp_q.pop_front();
      check($sformatf("w4_stream%0d", i), {if4.cout, if4.sum}, 64'(e));
      check($sformatf("w4_stream%0d_valid", i), 64'(if4.out_valid), 64'h1);
    end
    drive4(1'b0, 4'h0, 4'h0, 1'b0);
    sample();
    check("w4_stream_end_valid", 64'(if4.out_valid), 64'h0);

    // ---- mid-stream reset discards the pending operand ----
    drive4(1'b1, 4'h5, 4'h6, 1'b0);
    rst_n = 1'b0;
    sample();
    check("w4_midrst", {if4.out_valid, if4.cout, if4.sum}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    if4.in_valid = 1'b0;
    sample();
    check("w4_midrst_idle", 64'(if4.out_valid), 64'h0);

`ifdef FULL_ADDER_OVF_EN
    // ---- signed overflow, WIDTH=4 ----
    drive4(1'b1, 4'h7, 4'h1, 1'b0);
    sample();
    check("ovf_7p1", {if4.ovf, if4.cout, if4.sum}, 64'h28);
    drive4(1'b1, 4'h8, 4'h8, 1'b0);
    sample();
    check("ovf_8p8", {if4.ovf, if4.cout, if4.sum}, 64'h30);
    drive4(1'b0, 4'h3, 4'h2, 1'b0);
    sample();
    check("ovf_hold", 64'(if4.ovf), 64'h1);
    drive4(1'b1, 4'h3, 4'h2, 1'b0);
    sample();
    check("ovf_3p2", {if4.ovf, if4.cout, if4.sum}, 64'h05);
    drive4(1'b1, 4'hF, 4'hF, 1'b1);
    sample();
    check("ovf_m1m1c", {if4.ovf, if4.cout, if4.sum}, 64'h1F);
    drive4(1'b0, 4'h0, 4'h0, 1'b0);
`endif

    // ---- final report ----
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
